// File: rtl/cep_divider_pkg.sv
// Shared CEP ALU definitions: operand/result widths, divider states and the
// quotient reported for a zero divisor.
package cep_alu_pkg;

    localparam int DW = 11;
    localparam int VW = 5;
    localparam int CW = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } div_state_e;

    localparam logic [DW-1:0] QUOT_DIV0 = 11'h7FF;

endpackage

// File: rtl/cep_divider_if.sv
// Start/busy/done handshake and operand/result bus of the CEP divider.
interface cep_divider_if;
    import cep_alu_pkg::*;

    logic          start;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic          busy;
    logic          done;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          div_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_zero
    );

endinterface

// File: rtl/cep_divider_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module div_step
    import cep_alu_pkg::*;
(
    input  logic [VW:0]   r_i,
    input  logic          bit_i,
    input  logic [VW-1:0] v_i,
    output logic [VW:0]   r_o,
    output logic          q_o
);

    logic [VW+1:0] rs;
    logic [VW+1:0] v_ext;

    assign rs    = {r_i, bit_i};
    assign v_ext = {2'b00, v_i};

    // r_i is always below the divisor, so the result fits back in VW+1 bits.
    always_comb begin
        q_o = 1'b0;
        r_o = (VW+1)'(rs);
        if (rs >= v_ext) begin
            q_o = 1'b1;
            r_o = (VW+1)'(rs - v_ext);
        end
    end

endmodule

// File: rtl/cep_divider.sv
// Sequential restoring divider, one quotient bit per clock MSB first, with a
// start/busy/done handshake and registered results.
module cep_divider
    import cep_alu_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    cep_divider_if.slave  bus
);

    div_state_e    state_q;
    logic [DW-1:0] n_q;
    logic [VW-1:0] v_q;
    logic [VW:0]   r_q;
    logic [DW-1:0] quot_q;
    logic [CW-1:0] cnt_q;
    logic          busy_q;
    logic          done_q;
    logic [DW-1:0] quotient_q;
    logic [VW-1:0] remainder_q;
    logic          div_zero_q;

    logic [VW:0]   r_d;
    logic          q_bit_d;

    div_step u_step (
        .r_i   (r_q),
        .bit_i (n_q[DW-1]),
        .v_i   (v_q),
        .r_o   (r_d),
        .q_o   (q_bit_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            n_q         <= '0;
            v_q         <= '0;
            r_q         <= '0;
            quot_q      <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            div_zero_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        n_q    <= bus.dividend;
                        v_q    <= bus.divisor;
                        r_q    <= '0;
                        quot_q <= '0;
                        cnt_q  <= CW'(DW - 1);
                        // A zero divisor skips iteration and reports the saturated quotient.
                        if (bus.divisor == '0) begin
                            state_q     <= DONE;
                            done_q      <= 1'b1;
                            quotient_q  <= QUOT_DIV0;
                            remainder_q <= '0;
                            div_zero_q  <= 1'b1;
                        end else begin
                            state_q <= RUN;
                            busy_q  <= 1'b1;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    n_q    <= n_q << 1;
                    r_q    <= r_d;
                    quot_q <= {quot_q[DW-2:0], q_bit_d};
                    if (cnt_q == '0) begin
                        state_q     <= DONE;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        quotient_q  <= {quot_q[DW-2:0], q_bit_d};
                        remainder_q <= r_d[VW-1:0];
                        div_zero_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.quotient  = quotient_q;
    assign bus.remainder = remainder_q;
    assign bus.div_zero  = div_zero_q;

endmodule

// File: tb/tb_cep_divider.sv
// Self-checking bench for cep_divider: table of divisions plus hand-written
// mid-RUN start, mid-RUN reset and back-to-back sequences.
module tb_cep_divider;

    typedef struct {
        logic [10:0] dividend;
        logic [4:0]  divisor;
        logic [10:0] expQ;
        logic [4:0]  expR;
        logic        expZ;
    } vec_t;

    typedef struct {
        logic [10:0] q;
        logic [4:0]  r;
        logic        z;
    } exp_t;

    logic clk;
    logic rst;
    int   cycleCount;
    int   acceptCycle;
    int   doneCycle;
    int   nCompared;
    int   nMismatched;
    exp_t expQueue[$];
    vec_t vecs[6];

    cep_divider_if bus();

    cep_divider dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Presents one operation for a single accepting edge.
    task automatic applyStimulus(input logic [10:0] dvd, input logic [4:0] dvs,
                                 input logic [10:0] q, input logic [4:0] r,
                                 input logic z, input bit pushExp);
        exp_t e;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = dvd;
        bus.divisor  = dvs;
        if (pushExp) begin
            e.q = q; e.r = r; e.z = z;
            expQueue.push_back(e);
        end
        @(posedge clk);
        #1;
        acceptCycle = cycleCount;
        bus.start   = 1'b0;
    endtask

    // Waits (bounded) for done and compares against the scoreboard head.
    task automatic checkOutput(input string name, input int expLatency);
        int   waited;
        exp_t e;
        waited = 0;
        while (bus.done !== 1'b1 && waited < 40) begin
            @(posedge clk);
            #1;
            waited++;
        end
        doneCycle = cycleCount;
        if (bus.done !== 1'b1) begin
            checkValue({name, " done timeout"}, 32'(bus.done), 32'd1);
        end else if (expQueue.size() == 0) begin
            checkValue({name, " unexpected done"}, 32'd1, 32'd0);
        end else begin
            e = expQueue.pop_front();
            checkValue({name, " quotient"},  32'(bus.quotient),  32'(e.q));
            checkValue({name, " remainder"}, 32'(bus.remainder), 32'(e.r));
            checkValue({name, " div_zero"},  32'(bus.div_zero),  32'(e.z));
            checkValue({name, " latency"},   32'(doneCycle - acceptCycle), 32'(expLatency));
            checkValue({name, " busy at done"}, 32'(bus.busy), 32'd0);
        end
    endtask

    initial begin
        int firstDone;

        vecs[0] = '{11'd665,  5'd19, 11'd35,    5'd0, 1'b0};
        vecs[1] = '{11'd2047, 5'd31, 11'd66,    5'd1, 1'b0};
        vecs[2] = '{11'd5,    5'd7,  11'd0,     5'd5, 1'b0};
        vecs[3] = '{11'd31,   5'd1,  11'd31,    5'd0, 1'b0};
        vecs[4] = '{11'd100,  5'd0,  11'h7FF,   5'd0, 1'b1};
        vecs[5] = '{11'd100,  5'd4,  11'd25,    5'd0, 1'b0};

        cycleCount   = 0;
        nCompared    = 0;
        nMismatched  = 0;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        rst          = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkValue("reset busy",      32'(bus.busy),      32'd0);
        checkValue("reset done",      32'(bus.done),      32'd0);
        checkValue("reset quotient",  32'(bus.quotient),  32'd0);
        checkValue("reset remainder", 32'(bus.remainder), 32'd0);
        checkValue("reset div_zero",  32'(bus.div_zero),  32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].dividend, vecs[i].divisor, vecs[i].expQ,
                          vecs[i].expR, vecs[i].expZ, 1'b1);
            if (vecs[i].divisor != 5'd0)
                checkValue($sformatf("vec%0d busy after start", i), 32'(bus.busy), 32'd1);
            checkOutput($sformatf("vec%0d", i), (vecs[i].divisor == 5'd0) ? 0 : 11);
            @(posedge clk);
            #1;
            checkValue($sformatf("vec%0d done pulse width", i), 32'(bus.done), 32'd0);
            checkValue($sformatf("vec%0d quotient hold", i), 32'(bus.quotient), 32'(vecs[i].expQ));
        end

        // Start pulse mid-RUN with other operands must be ignored.
        applyStimulus(11'd665, 5'd19, 11'd35, 5'd0, 1'b0, 1'b1);
        firstDone = acceptCycle;
        repeat (3) @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 11'd100;
        bus.divisor  = 5'd3;
        @(negedge clk);
        bus.start = 1'b0;
        acceptCycle = firstDone;
        checkOutput("midrun start", 11);

        // Asynchronous reset during RUN step 5 discards the operation.
        applyStimulus(11'd500, 5'd7, 11'd0, 5'd0, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkValue("midrun rst busy",      32'(bus.busy),      32'd0);
        checkValue("midrun rst done",      32'(bus.done),      32'd0);
        checkValue("midrun rst quotient",  32'(bus.quotient),  32'd0);
        checkValue("midrun rst remainder", 32'(bus.remainder), 32'd0);
        repeat (8) @(posedge clk);
        #1;
        checkValue("rst held no done", 32'(bus.done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(11'd1000, 5'd9, 11'd111, 5'd1, 1'b0, 1'b1);
        checkOutput("after rst 1000/9", 11);

        // Back-to-back: start held through DONE, next done exactly 12 cycles later.
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 11'd665;
        bus.divisor  = 5'd19;
        expQueue.push_back('{11'd35, 5'd0, 1'b0});
        @(posedge clk);
        #1;
        acceptCycle = cycleCount;
        checkOutput("b2b first", 11);
        firstDone    = doneCycle;
        bus.dividend = 11'd2047;
        bus.divisor  = 5'd31;
        expQueue.push_back('{11'd66, 5'd1, 1'b0});
        @(posedge clk);
        #1;
        acceptCycle = cycleCount;
        bus.start   = 1'b0;
        checkValue("b2b restart busy", 32'(bus.busy), 32'd1);
        checkValue("b2b restart done", 32'(bus.done), 32'd0);
        checkOutput("b2b second", 11);
        checkValue("b2b done spacing", 32'(doneCycle - firstDone), 32'd12);

        checkValue("scoreboard drained", 32'(expQueue.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
